// File: rtl/ma_pkg.sv
// Shared definitions for the memory-access stage: MA control bit indices,
// access-size encodings, FSM states and address-alignment helpers.
package ma_pkg;

  localparam int unsigned MA_EN = 0;
  localparam int unsigned MA_RW = 1;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } ma_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } ma_state_e;

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  // Clears the low address bits a given size cannot use.
  function automatic logic [1:0] align_lo(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: return lo;
      SZ_HALF: return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ma_lane_format.sv
// Combinational lane logic: store byte-enables / lane replication and
// load lane extraction with sign or zero extension.
module ma_lane_format
  import ma_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lo,
  input  logic        ld_sign,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;

  always_comb begin
    st_be    = 4'hF;
    st_wdata = st_data;
    case (st_size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << st_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_be    = 4'b0011 << {st_lo[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'hF;
        st_wdata = st_data;
      end
    endcase
  end

  always_comb begin
    ld_shift = ld_rdata >> {ld_lo, 3'b000};
    ld_data  = ld_rdata;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_sign & ld_shift[7]}}, ld_shift[7:0]};
      SZ_HALF: ld_data = {{16{ld_sign & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline memory-access stage with request/acknowledge data-cache handshake,
// timeout bus error, and optional misaligned-access trap (MA_MISALIGN_TRAP_EN).
module mem_access_unit
  import ma_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [2:0]        WB_in,
  input  logic [1:0]        MA,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] ALU_rsl_in,
  input  logic [31:0]       Rs2_val,
  input  logic [REG_AW-1:0] Rs2_address,
  input  logic [31:0]       PC_in,
  input  logic [REG_AW-1:0] Rdst_in,
  input  logic [31:0]       mux_wb,
  input  logic              OP1_MemS,
  output logic [31:0]       PC_out,
  output logic [REG_AW-1:0] Rdst_out,
  output logic [ADDR_W-1:0] ALU_rsl_out,
  output logic [2:0]        WB_out,
  output logic [REG_AW-1:0] EX_MEM_Rs2,
  output logic [1:0]        EX_MEM_MA,
  output logic              stall,
  output logic              miss,
  output logic [31:0]       mem_out,
  output logic              fault,
  output logic              dc_req,
  output logic              dc_we,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [31:0]       dc_wdata,
  output logic [3:0]        dc_be,
  input  logic              dc_ack,
  input  logic [31:0]       dc_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  ma_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       req_size;
  logic [1:0]       req_lo;
  logic             req_sign;

  logic [1:0]  st_lo;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        trap;

  assign PC_out      = PC_in;
  assign Rdst_out    = Rdst_in;
  assign ALU_rsl_out = ALU_rsl_in;
  assign WB_out      = WB_in;
  assign EX_MEM_Rs2  = Rs2_address;
  assign EX_MEM_MA   = MA;

  assign dc_req = (state == ST_REQ);
  assign miss   = (state == ST_REQ);
  assign stall  = ((state == ST_IDLE) && MA[MA_EN]) || (state == ST_REQ);

  assign st_lo   = align_lo(size, ALU_rsl_in[1:0]);
  assign st_data = OP1_MemS ? mux_wb : Rs2_val;

  always_comb begin
    trap = 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
    trap = is_misaligned(size, ALU_rsl_in[1:0]);
`endif
  end

  ma_lane_format u_lane (
    .st_size  (size),
    .st_lo    (st_lo),
    .st_data  (st_data),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_size  (req_size),
    .ld_lo    (req_lo),
    .ld_sign  (req_sign),
    .ld_rdata (dc_rdata),
    .ld_data  (ld_data)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      req_size <= '0;
      req_lo   <= '0;
      req_sign <= 1'b0;
      dc_we    <= 1'b0;
      dc_addr  <= '0;
      dc_wdata <= '0;
      dc_be    <= '0;
      mem_out  <= '0;
      fault    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (MA[MA_EN]) begin
            if (trap) begin
              fault <= 1'b1;
              state <= ST_DONE;
            end else begin
              req_size <= size;
              req_lo   <= st_lo;
              req_sign <= sign_ext;
              dc_we    <= MA[MA_RW];
              dc_addr  <= {ALU_rsl_in[ADDR_W-1:2], 2'b00};
              dc_wdata <= st_wdata;
              dc_be    <= st_be;
              state    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // An ack on the last allowed cycle still wins over the timeout.
          if (dc_ack) begin
            if (!dc_we) mem_out <= ld_data;
            state <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            mem_out <= '0;
            fault   <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          fault <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
